// File: rtl/psum_accumulator.sv
// Accumulates skewed per-column partial sums across input-channel tiles and, on the
// last tile, streams sign-binarized activation words (one per output row) over AXI-Stream.
module psum_accumulator #(
    parameter int COLS  = 32,
    parameter int DEPTH = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tile_start,
    input  logic                    tile_first,
    input  logic                    tile_last,
    input  logic [$clog2(DEPTH):0]  num_rows,
    input  logic [$clog2(COLS)-1:0] last_col,
    input  logic [COLS*16-1:0]      partialsum_in,
    input  logic [COLS-1:0]         partialsum_in_valid,
    output logic [31:0]             m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    busy,
    output logic                    sat_flag
);
    localparam int DATA_W = 16;
    localparam int AW     = $clog2(DEPTH);
    localparam int NW     = AW + 1;
    localparam int CW     = $clog2(COLS);

    localparam logic signed [DATA_W:0] SUM_MAX = 17'sh0_7FFF;
    localparam logic signed [DATA_W:0] SUM_MIN = 17'sh1_8000;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    state_t                   state;
    logic                     first_q;
    logic                     last_q;
    logic [NW-1:0]            rows_q;
    logic [CW-1:0]            lcol_q;
    logic [NW-1:0]            cnt [COLS];
    logic [NW-1:0]            rd_ptr;
    logic signed [DATA_W-1:0] mem [COLS][DEPTH];

    logic [COLS-1:0]          wr_en_p0;
    logic [COLS-1:0]          wr_sat_p0;
    logic signed [DATA_W-1:0] wr_val_p0 [COLS];
    logic                     all_done;
    logic [NW-1:0]            rd_next;
    logic [31:0]              word_next;

    function automatic logic signed [DATA_W-1:0] sat16(input logic signed [DATA_W:0] s);
        if (s > SUM_MAX)
            return 16'sh7FFF;
        else if (s < SUM_MIN)
            return 16'sh8000;
        else
            return s[DATA_W-1:0];
    endfunction

    function automatic logic ovf16(input logic signed [DATA_W:0] s);
        return (s > SUM_MAX) || (s < SUM_MIN);
    endfunction

    assign busy = (state != IDLE);

    // p0: per-column write decision and saturating sum, from the current beat and bank word
    always_comb begin
        logic signed [DATA_W-1:0] ps;
        logic signed [DATA_W-1:0] old;
        logic signed [DATA_W:0]   sum;
        logic                     active;
        wr_en_p0  = '0;
        wr_sat_p0 = '0;
        all_done  = 1'b1;
        for (int j = 0; j < COLS; j++) begin
            ps     = partialsum_in[j*DATA_W +: DATA_W];
            old    = mem[j][cnt[j][AW-1:0]];
            sum    = {old[DATA_W-1], old} + {ps[DATA_W-1], ps};
            active = (j <= int'(lcol_q));
            if (active && (cnt[j] != rows_q))
                all_done = 1'b0;
            if ((state == ACCUM) && active && partialsum_in_valid[j] && (cnt[j] < rows_q))
                wr_en_p0[j] = 1'b1;
            wr_val_p0[j] = first_q ? ps : sat16(sum);
            wr_sat_p0[j] = wr_en_p0[j] && !first_q && ovf16(sum);
        end

        // Next word to present: row 0 on entry to DRAIN, else the row after the current one
        rd_next   = (state == ACCUM) ? '0 : rd_ptr + 1'b1;
        word_next = '0;
        for (int j = 0; j < COLS; j++) begin
            if (j <= int'(lcol_q))
                word_next[j] = ~mem[j][rd_next[AW-1:0]][DATA_W-1];
        end
    end

    // p1: bank, counters, FSM and registered stream outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            first_q       <= 1'b0;
            last_q        <= 1'b0;
            rows_q        <= '0;
            lcol_q        <= '0;
            rd_ptr        <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            sat_flag      <= 1'b0;
            for (int j = 0; j < COLS; j++) begin
                cnt[j] <= '0;
                for (int r = 0; r < DEPTH; r++)
                    mem[j][r] <= '0;
            end
        end else begin
            for (int j = 0; j < COLS; j++) begin
                if (wr_en_p0[j]) begin
                    mem[j][cnt[j][AW-1:0]] <= wr_val_p0[j];
                    cnt[j]                 <= cnt[j] + 1'b1;
                end
            end
            if (|wr_sat_p0)
                sat_flag <= 1'b1;

            case (state)
                IDLE: begin
                    if (tile_start && (num_rows != '0)) begin
                        first_q <= tile_first;
                        last_q  <= tile_last;
                        rows_q  <= num_rows;
                        lcol_q  <= last_col;
                        for (int j = 0; j < COLS; j++)
                            cnt[j] <= '0;
                        if (tile_first)
                            sat_flag <= 1'b0;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (all_done) begin
                        if (last_q) begin
                            state         <= DRAIN;
                            rd_ptr        <= '0;
                            m_axis_tvalid <= 1'b1;
                            m_axis_tdata  <= word_next;
                            m_axis_tlast  <= (rows_q == NW'(1));
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DRAIN: begin
                    if (m_axis_tready) begin
                        if (m_axis_tlast) begin
                            state         <= IDLE;
                            rd_ptr        <= '0;
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                        end else begin
                            rd_ptr       <= rd_next;
                            m_axis_tdata <= word_next;
                            m_axis_tlast <= (rd_next == rows_q - 1'b1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/psum_accumulator.md
# psum_accumulator

Downstream stage of the systolic array. It captures the skewed per-column partial-sum streams leaving row 0 and accumulates them across input-channel tiles in a register bank. On the final tile it binarizes each accumulated value by sign and streams one packed activation word per output row over an AXI-Stream master. Its output is the next layer's binary activations.

## Interface
Parameters:
- COLS, 32: array columns; must be ≤ 32, one output bit per column.
- DEPTH, 64: maximum output rows per tile, i.e. accumulator words per column.

Ports:
- clk  in  1  system clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- tile_start  in  1  one-cycle pulse that begins a tile and latches the four configuration inputs below.
- tile_first  in  1  on this tile, overwrite the accumulators instead of adding.
- tile_last  in  1  on this tile, binarize and stream the result when done.
- num_rows  in  $clog2(DEPTH)+1  beats expected per active column, 1..DEPTH.
- last_col  in  $clog2(COLS)  highest active column index.
- partialsum_in  in  COLS*16  per-column signed partial sums; column j is [j*16+:16].
- partialsum_in_valid  in  COLS  per-column valid.
- m_axis_tdata  out  32  packed sign bits; bit j belongs to column j.
- m_axis_tvalid  out  1  AXI-Stream valid.
- m_axis_tready  in  1  AXI-Stream ready.
- m_axis_tlast  out  1  high on the final word of a tile.
- busy  out  1  high from the cycle after an accepted tile_start until the return to IDLE.
- sat_flag  out  1  sticky; set when any accumulation saturated.

## Operation
- States are IDLE, ACCUM and DRAIN.
- IDLE → ACCUM on tile_start with num_rows≠0.
  - The configuration is latched on that edge.
  - Every per-column write counter cnt[j] is cleared to 0.
  - A tile_start with num_rows=0, or any tile_start outside IDLE, is ignored.
- In ACCUM, for each column j ≤ last_col with partialsum_in_valid[j]=1 and cnt[j] < num_rows:
  - If first: mem[cnt[j]][j] ← psum.
  - Otherwise: mem[cnt[j]][j] ← sat16(mem + psum).
  - Then cnt[j] increments.
  - Columns are independent. Each column's beats are written in arrival order regardless of skew between columns.
- Beats are dropped with no state change in these cases:
  - valid on a column j > last_col;
  - valid when cnt[j] = num_rows;
  - valid in IDLE or DRAIN.
- Arithmetic: a 17-bit signed sum clamped to [-32768, 32767]. Any clamp sets sat_flag.
- sat_flag clears on an accepted tile_start with tile_first=1, and on rst.
- Completion: all_done = (cnt[j] = num_rows for every j ≤ last_col).
  - ACCUM with all_done and last=0 → IDLE.
  - ACCUM with all_done and last=1 → DRAIN, with rd_ptr=0.
- DRAIN:
  - m_axis_tvalid=1.
  - m_axis_tdata bit j = ~mem[rd_ptr][j][15] for j ≤ last_col, so a value ≥ 0 gives 1. Bits above last_col read 0.
  - m_axis_tlast = (rd_ptr = num_rows-1).
  - On tvalid&tready, rd_ptr increments. A handshake on the tlast word → IDLE.
- The accumulator bank persists across tiles; it is cleared only by rst.

## Timing
- Reset values:
  - state=IDLE, all cnt=0, rd_ptr=0, all mem=0.
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
  - busy=0, sat_flag=0.
- Accumulation has single-cycle latency: the edge that samples a valid beat writes mem and increments cnt.
- The transition out of ACCUM occurs on the edge after the one that writes the final beat. In a last tile, m_axis_tvalid is first high in the following cycle.
- tdata and tlast are held stable while tvalid=1 and tready=0. tvalid never drops without a handshake.
- Throughput in DRAIN is one word per cycle with tready held high.
- busy falls in the same cycle the state returns to IDLE. A tile_start in that cycle is accepted.
- rst mid-tile, in ACCUM or DRAIN, aborts immediately. tvalid is 0 in the next cycle, and mem is zeroed.

## Test plan
- **Single tile, first=last=1, num_rows=4, last_col=3.**
  - Stimulus: column j receives values {5,-1,0,-7} with a j-cycle skew, tready=1.
  - Required: 4 words 0x0000000F, 0x00000000, 0x0000000F, 0x00000000; tlast on word 3.
  - Required: tvalid first high 2 cycles after column 3's last beat.
- **Two tiles, num_rows=2, last_col=0.**
  - Stimulus: tile 1 (first) feeds {3,-3}; tile 2 (last) feeds {-5,4}.
  - Required: words 0x0, 0x1; tile 1 emits nothing; busy low between tiles.
- **Saturation.**
  - Stimulus: tile 1 (first) feeds 30000; tile 2 (last) feeds 10000.
  - Required: mem=32767, sat_flag=1, output bit 1.
  - Required: a following tile_start with first=1 clears sat_flag.
- **Backpressure.**
  - Stimulus: a DRAIN of 3 words with tready toggling 0,0,1,0,1,1.
  - Required: tdata stable during stalls; exactly 3 handshakes; tlast only on the third.
- **Protocol edges.**
  - Stimulus: extra beats after cnt=num_rows, a beat on column last_col+1, a tile_start while busy, and num_rows=0.
  - Required: all are ignored; the output matches the clean run.
- **Reset mid-DRAIN.**
  - Stimulus: assert rst after 1 of 4 words.
  - Required: tvalid=0 next cycle, busy=0, and a fresh tile produces correct output from zeroed state.
